modexp_scheduler: RTL
=====================

Name: modexp_scheduler

Overview:
- Sequences the shared modular multiply/modulo datapath through left-to-right square-and-multiply modular exponentiation.
- Holds the exponent and scans it MSB-first. For each bit it issues a square, plus a multiply-by-base when the bit is set.
- Handshakes with the mod-mul unit via start/done pulses.
- Sits between the top-level command decode (exponent update / data input) and the mod-mul datapath. The datapath owns the accumulator, base and modulus registers.

Parameters:
- E_WIDTH, 16, exponent width in bits; must be at least 2.
- IDX_W, $clog2(E_WIDTH), width of bit_idx.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_exp  in  1  load exp_in into exponent register; honoured only when busy=0.
- exp_in  in  E_WIDTH  new exponent value.
- start  in  1  begin exponentiation; honoured only in IDLE.
- mm_done  in  1  one-cycle pulse from mod-mul unit: current operation complete.
- init_acc  out  1  one-cycle pulse: datapath loads accumulator with 1.
- mm_start  out  1  one-cycle pulse: launch a mod-mul operation.
- mm_sel  out  1  operation select, valid with mm_start: 0 = acc*acc, 1 = acc*base.
- bit_idx  out  IDX_W  exponent bit currently being processed.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: result valid in accumulator.

Behaviour:
- Reset (async, any state): state=IDLE; exponent register=0; bit_idx=E_WIDTH-1; init_acc, mm_start, mm_sel, busy, done all 0.
- All outputs are registered or decoded from the registered state. No combinational path exists from mm_done or start to mm_start.
- States and transitions:
  - IDLE: on start, go to INIT. load_exp updates the exponent register. If load_exp and start arrive in the same cycle, the newly loaded exponent is used.
  - INIT: init_acc=1 for 1 cycle. bit_idx is set to the start index (E_WIDTH-1, or see Optional Feature). Go to SQUARE.
  - SQUARE: mm_start=1, mm_sel=0 for 1 cycle. Go to WAIT_SQ.
  - WAIT_SQ: hold until mm_done. Then go to MULT if exp[bit_idx]=1, else NEXT.
  - MULT: mm_start=1, mm_sel=1 for 1 cycle. Go to WAIT_MUL.
  - WAIT_MUL: hold until mm_done, then go to NEXT.
  - NEXT: if bit_idx==0, go to DONE. Else bit_idx decrements by 1 and go to SQUARE.
  - DONE: done=1 for 1 cycle, then go to IDLE.
- Latency:
  - start to first mm_start: 2 cycles.
  - mm_done to the next mm_start: 1 cycle (MULT) or 2 cycles (via NEXT).
  - Final mm_done to done: 2 cycles.
- mm_done outside WAIT_SQ/WAIT_MUL is ignored, with no state change.
- start while busy is ignored; the in-flight operation continues unchanged.
- load_exp while busy is ignored; the exponent register is unchanged.
- mm_done on the same cycle as mm_start cannot occur, because mm_start is issued from a non-wait state. The bench must not drive it.
- Exponent 0 (feature off): E_WIDTH squares, 0 multiplies, result 1.
- bit_idx never wraps. It is checked for 0 before any decrement.

Optional Feature:
- Macro: MODEXP_SKIP_LZ_EN.
- Defined:
  - INIT sets bit_idx to the index of the highest set exponent bit, computed by a priority encoder on the exponent register.
  - If the exponent is 0, INIT goes directly to DONE: init_acc pulses, there is no mm_start, and done follows 1 cycle after INIT.
- Undefined:
  - bit_idx starts at E_WIDTH-1 and every bit is processed, including leading zeros (squares of 1).
- Results are identical either way; only operation count and latency differ.

Test Plan:
- E_WIDTH=4, load 4'b1011, start; mm_done driven 2 cycles after each mm_start.
  - Required mm_sel sequence: 0,1,0,0,1,0,1.
  - bit_idx at each square: 3,2,1,0.
  - done pulses once; busy falls with return to IDLE.
- Load 4'b0101, start.
  - Feature off: mm_sel sequence 0,0,1,0,0,1.
  - MODEXP_SKIP_LZ_EN on: mm_sel sequence 0,1,0,0,1, first square at bit_idx=2.
- Load 0, start.
  - Feature off: 4 squares, 0 multiplies, then done.
  - Feature on: init_acc, then done 1 cycle later, with no mm_start.
- During WAIT_SQ, pulse start and pulse load_exp with 4'b1111.
  - Both are ignored: sequence completes per the original exponent.
  - A following start then uses the old exponent.
- Pulse mm_done in IDLE and in SQUARE.
  - No state change and no extra mm_start.
  - Sequence timing is unaffected.
- Assert rst asynchronously mid-WAIT_MUL (between clock edges).
  - Outputs clear immediately: busy=0, exponent register=0.
  - A later mm_done is ignored, and a new start runs a full 4-square sequence.

Source files
------------

// File: rtl/modexp_scheduler.sv
// Control sequencer for left-to-right square-and-multiply modular exponentiation.
// Optional build macro MODEXP_SKIP_LZ_EN: start the scan at the highest set exponent bit.
module modexp_scheduler #(
   parameter int E_WIDTH = 16,
   parameter int IDX_W   = $clog2(E_WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_exp,
   input  logic [E_WIDTH-1:0] exp_in,
   input  logic               start,
   input  logic               mm_done,
   output logic               init_acc,
   output logic               mm_start,
   output logic               mm_sel,
   output logic [IDX_W-1:0]   bit_idx,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SQUARE,
      WAIT_SQ,
      MULT,
      WAIT_MUL,
      NEXT,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(E_WIDTH - 1);

   state_t             state_q, state_d;
   logic [E_WIDTH-1:0] exp_q, exp_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

`ifdef MODEXP_SKIP_LZ_EN
   logic [IDX_W-1:0] lz_idx;

   // Priority encoder: the last set bit seen while scanning upward wins.
   always_comb begin
      lz_idx = '0;
      for (int i = 0; i < E_WIDTH; i++) begin
         if (exp_q[i]) begin
            lz_idx = IDX_W'(i);
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         exp_q   <= '0;
         idx_q   <= TOP_IDX;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (load_exp) begin
               exp_d = exp_in;
            end
            if (start) begin
               state_d = INIT;
            end
         end
         INIT: begin
`ifdef MODEXP_SKIP_LZ_EN
            idx_d   = lz_idx;
            state_d = (exp_q == '0) ? DONE : SQUARE;
`else
            idx_d   = TOP_IDX;
            state_d = SQUARE;
`endif
         end
         SQUARE: begin
            state_d = WAIT_SQ;
         end
         WAIT_SQ: begin
            if (mm_done) begin
               state_d = exp_q[idx_q] ? MULT : NEXT;
            end
         end
         MULT: begin
            state_d = WAIT_MUL;
         end
         WAIT_MUL: begin
            if (mm_done) begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            // Test for zero before decrementing so the index never wraps.
            if (idx_q == '0) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q - IDX_W'(1);
               state_d = SQUARE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign init_acc = (state_q == INIT);
   assign mm_start = (state_q == SQUARE) || (state_q == MULT);
   assign mm_sel   = (state_q == MULT);
   assign bit_idx  = idx_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

endmodule
